// File: rtl/ram_loader.sv
// ram_loader: assembles a little-endian byte stream into 32-bit RAM words and verifies the checksum
module ram_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_set,
  output logic [15:0] o_addr,
  output logic [31:0] o_data,
  output logic        o_busy,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_err
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] len_lo, sum;
  logic [15:0] n, idx, len;
  logic [1:0] cnt;
  logic [23:0] sh;
  logic acc, len_ok, last, go;
  always_comb begin
    o_busy = state inside {LEN0, LEN1, DATA, CSUM};
    o_byte_ready = o_busy;
    o_cpu_hold = o_busy;
    acc = i_byte_valid && o_byte_ready;
    go = (state == IDLE || state == DONE) && i_start;
    len = {i_byte, len_lo};
    len_ok = len != 16'd0 && 32'(len) <= MAX_WORDS;
    last = cnt == 2'd3 && idx == n - 16'd1;
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (i_start) state_nx = LEN0;
      LEN0:       if (acc) state_nx = LEN1;
      LEN1:       if (acc) state_nx = len_ok ? DATA : DONE;
      DATA:       if (acc && last) state_nx = CSUM;
      CSUM:       if (acc) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_set <= 1'b0;
      o_addr <= '0;
      o_data <= '0;
      o_done <= 1'b0;
      o_err <= 1'b0;
      len_lo <= '0;
      n <= '0;
      idx <= '0;
      cnt <= '0;
      sh <= '0;
      sum <= '0;
    end else begin
      o_set <= 1'b0;
      if (go) begin
        o_done <= 1'b0;
        o_err <= 1'b0;
        idx <= '0;
        cnt <= '0;
        sum <= '0;
      end
      if (acc && state == LEN0) len_lo <= i_byte;
      if (acc && state == LEN1) begin
        n <= len;
        if (!len_ok) begin
          o_done <= 1'b1;
          o_err <= 1'b1;
        end
      end
      if (acc && state == DATA) begin
        cnt <= cnt + 2'd1;
        sh <= {i_byte, sh[23:8]};
        sum <= sum + i_byte;
        if (cnt == 2'd3) begin
          o_set <= 1'b1;
          o_addr <= idx;
          o_data <= {i_byte, sh};
          idx <= idx + 16'd1;
        end
      end
      if (acc && state == CSUM) begin
        o_done <= 1'b1;
        o_err <= i_byte != sum;
      end
    end
  end
endmodule

// File: doc/ram_loader.md
# ram_loader

Serial program loader sitting directly upstream of the processor RAM. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each completed word is written into the RAM through its write port, at consecutive word addresses starting at 0. While loading, it holds the CPU off, then reports completion and checksum status.

## Interface
- MAX_WORDS, 256: largest accepted word count; must not exceed RAM depth.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins a load when in IDLE or DONE, ignored otherwise.
- i_byte  in  8  incoming stream byte.
- i_byte_valid  in  1  i_byte is valid this cycle.
- o_byte_ready  out  1  loader can accept a byte this cycle.
- o_set  out  1  RAM write strobe; drives RAM i_set.
- o_addr  out  16  RAM word address; drives RAM i_addr.
- o_data  out  32  RAM write data; drives RAM i_data.
- o_busy  out  1  load in progress.
- o_cpu_hold  out  1  equals o_busy; stalls the CPU.
- o_done  out  1  load finished; stays high until next i_start.
- o_err  out  1  load finished with error; valid while o_done=1.

## Operation
- Stream format:
  - 2-byte word count N, low byte first.
  - 4N data bytes; each word is sent least-significant byte first.
  - 1 checksum byte = sum of all 4N data bytes, mod 256.
- States and transitions:
  - IDLE: the reset state.
  - IDLE or DONE -> LEN0 on i_start.
  - LEN0 -> LEN1 on accept.
  - LEN1 -> DATA on accept, if 1 <= N <= MAX_WORDS.
  - LEN1 -> DONE with o_err=1 otherwise. No write occurs in that case.
  - DATA -> CSUM after accept of byte 4N.
  - CSUM -> DONE on accept; o_err = (received byte != running sum).
- A byte is accepted only on a cycle with i_byte_valid && o_byte_ready. o_byte_ready=1 exactly in LEN0, LEN1, DATA and CSUM. i_byte is ignored in all other states.
- DATA state bookkeeping:
  - A 2-bit byte counter and a 24-bit shift register hold partial words.
  - A 16-bit word index starts at 0.
  - An 8-bit running sum accumulates every data byte, wrapping mod 256.
- On accept of the 4th byte of word k, at that clock edge:
  - o_data <= {i_byte, bytes2, bytes1, bytes0}
  - o_addr <= k
  - o_set <= 1 for exactly one cycle
  - the word index increments.
- The RAM captures the write on the following edge.
- On i_start from DONE: o_done and o_err clear, and the index, counters and sum reset to 0.
- o_busy=1 in LEN0, LEN1, DATA and CSUM.
- A checksum mismatch does not undo writes already performed.

## Timing
- Reset (asynchronous, immediate), all outputs go to:
  - o_set=0, o_addr=0, o_data=0
  - o_byte_ready=0, o_busy=0, o_cpu_hold=0
  - o_done=0, o_err=0
  - state=IDLE.
- Reset mid-load abandons the load. RAM words already written are kept. The next i_start restarts from address 0.
- i_start -> o_busy and o_byte_ready high on the next cycle.
- Write latency: o_set is high in the cycle after the 4th byte of the word is accepted. o_addr and o_data are stable during that cycle and hold their values afterwards.
- Throughput: one byte per cycle with no bubbles. Back-to-back words produce o_set on every 4th cycle.
- Gaps in i_byte_valid stall the loader without state loss.
- o_done rises in the cycle after the checksum byte (or the failing LEN1 byte) is accepted. o_busy falls in the same cycle.
- i_start arriving in the same cycle as a byte accept in a busy state is ignored.
- Width rules:
  - Word count is 16-bit unsigned; a value of 65535 is legal only if MAX_WORDS allows it.
  - The word index never exceeds N-1, so no wrap occurs.

## Test plan
- Single word: start, then bytes 01 00 78 56 34 12 14 -> one o_set pulse with o_addr=0 and o_data=0x12345678, then o_done=1, o_err=0.
- Three words with random valid gaps:
  - Data 0x00000001, 0x00000002, 0x00000003; checksum 06.
  - Expect o_set at addresses 0, 1, 2 with matching data.
  - o_byte_ready stays high throughout DATA; o_err=0.
- Zero length, bytes 00 00 -> o_done=1, o_err=1, no o_set, o_byte_ready=0 afterwards.
- Oversize with MAX_WORDS=256, bytes 01 01 (N=257) -> o_done=1, o_err=1, no o_set.
- Bad checksum: the single-word stream with final byte 15 -> write to address 0 still occurs; o_done=1, o_err=1.
- Reset in DATA after 2 of 4 bytes -> all outputs 0 at once. A subsequent start plus a full single-word stream loads address 0 correctly with o_err=0.
